// File: rtl/axi_rd_arbiter_if.sv
// AXI3 read-address / read-data channel bundle shared by the arbiter and the slave.
// Only single-beat reads are issued, so rlast/rid are carried but not interpreted.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic [3:0]        arid;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [1:0]        arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [3:0]        rid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read channel between instruction fetch (port 0)
// and data load (port 1); one single-beat read in flight at a time.
module axi_rd_arbiter #(
   parameter logic [3:0] ID_INST = 4'd0,
   parameter logic [3:0] ID_DATA = 4'd1,
   parameter int         ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [1:0]        inst_size,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,

   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [1:0]        data_size,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,

   output logic              rd_err,

   axi_rd_arbiter_if.master  axi
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;          // 0 = inst, 1 = data
   logic              last_grant_q, last_grant_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [3:0]        arid_q, arid_d;
   logic [2:0]        arsize_q, arsize_d;
   logic              rready_q, rready_d;
   logic              inst_data_ok_q, inst_data_ok_d;
   logic              data_data_ok_q, data_data_ok_d;
   logic [31:0]       inst_rdata_q, inst_rdata_d;
   logic [31:0]       data_rdata_q, data_rdata_d;
   logic              rd_err_q, rd_err_d;

   logic              pick;
   logic              ar_hs;
   logic              r_hs;

   // Port 1 wins when it is the only requester, or when both request and port 0 went last.
   assign pick  = data_req && (!inst_req || !last_grant_q);
   assign ar_hs = arvalid_q && axi.arready;
   assign r_hs  = rready_q && axi.rvalid;

   always_comb begin
      // NOTE: every _d starts from its _q (or a pulse default) so no branch can infer a latch.
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      arvalid_d      = arvalid_q;
      araddr_d       = araddr_q;
      arid_d         = arid_q;
      arsize_d       = arsize_q;
      rready_d       = rready_q;
      inst_data_ok_d = 1'b0;
      data_data_ok_d = 1'b0;
      inst_rdata_d   = inst_rdata_q;
      data_rdata_d   = data_rdata_q;
      rd_err_d       = rd_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (inst_req || data_req) begin
               grant_d      = pick;
               last_grant_d = pick;
               araddr_d     = pick ? data_addr : inst_addr;
               arsize_d     = {1'b0, (pick ? data_size : inst_size)};
               arid_d       = pick ? ID_DATA : ID_INST;
               arvalid_d    = 1'b1;
               state_d      = S_AR;
            end
         end
         S_AR: begin
            // arvalid only drops on the handshake; address fields stay frozen until then.
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (r_hs) begin
               rready_d = 1'b0;
               state_d  = S_IDLE;
               if (grant_q) begin
                  data_rdata_d   = axi.rdata;
                  data_data_ok_d = 1'b1;
               end else begin
                  inst_rdata_d   = axi.rdata;
                  inst_data_ok_d = 1'b1;
               end
               if (axi.rresp != 2'b00) begin
                  rd_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         grant_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         arvalid_q      <= 1'b0;
         araddr_q       <= '0;
         arid_q         <= 4'd0;
         arsize_q       <= 3'd0;
         rready_q       <= 1'b0;
         inst_data_ok_q <= 1'b0;
         data_data_ok_q <= 1'b0;
         inst_rdata_q   <= 32'd0;
         data_rdata_q   <= 32'd0;
         rd_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         arvalid_q      <= arvalid_d;
         araddr_q       <= araddr_d;
         arid_q         <= arid_d;
         arsize_q       <= arsize_d;
         rready_q       <= rready_d;
         inst_data_ok_q <= inst_data_ok_d;
         data_data_ok_q <= data_data_ok_d;
         inst_rdata_q   <= inst_rdata_d;
         data_rdata_q   <= data_rdata_d;
         rd_err_q       <= rd_err_d;
      end
   end

   // Address acceptance is visible in the handshake cycle itself, hence combinational.
   assign inst_addr_ok = ar_hs && !grant_q;
   assign data_addr_ok = ar_hs &&  grant_q;
   assign inst_data_ok = inst_data_ok_q;
   assign data_data_ok = data_data_ok_q;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;
   assign rd_err       = rd_err_q;

   assign axi.arid    = arid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = 4'd0;
   assign axi.arsize  = arsize_q;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   // Single-beat reads routed by the registered grant, so rid and rlast carry no information.
   logic unused_r;
   assign unused_r = ^{axi.rid, axi.rlast};

endmodule
